// File: rtl/bus_pkg.sv
// Shared constants and FSM state type for the bus arbitration multiplexer.
package bus_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 4;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap-around,
// returning a one-hot grant and a valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] w_idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (!valid && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// N-source bus multiplexer with a registered output stage, round-robin or
// forced source selection, and a saturating count of malformed force_sel loads.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  input  logic               force_en,
  input  logic [N-1:0]       force_sel,
  input  logic               bus_ready,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic [N-1:0]       grant,
  output logic [7:0]         err_cnt,
  input  logic               clr_err
);

  localparam int PW = $clog2(N);

  state_t           r_state;
  logic [WIDTH-1:0] r_bus_out;
  logic [N-1:0]     r_grant;
  logic [PW-1:0]    r_ptr;
  logic [7:0]       r_err_cnt;

  logic             w_load;
  logic [N-1:0]     w_rr_gnt;
  logic             w_rr_valid;
  logic [PW:0]      w_sel_cnt;
  logic             w_force_ok;
  logic [N-1:0]     w_win;
  logic             w_has_win;
  logic             w_err;
  logic [WIDTH-1:0] w_data;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_next;

  assign w_load = (r_state == EMPTY) || bus_ready;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_rr_gnt),
    .valid (w_rr_valid)
  );

  always_comb begin
    w_sel_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_cnt = w_sel_cnt + {{PW{1'b0}}, force_sel[i]};
    end
  end

  assign w_force_ok = (w_sel_cnt == {{PW{1'b0}}, 1'b1});

  // A valid forced select whose source is idle simply yields no winner.
  always_comb begin
    if (force_en) begin
      w_win = w_force_ok ? (force_sel & req) : '0;
    end else begin
      w_win = w_rr_valid ? w_rr_gnt : '0;
    end
  end

  assign w_has_win = |w_win;
  assign w_err     = w_load && force_en && !w_force_ok;

  always_comb begin
    w_data = '0;
    w_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win[i]) begin
        w_data = din[i*WIDTH +: WIDTH];
        w_idx  = PW'(i);
      end
    end
  end

  assign w_ptr_next = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= EMPTY;
      r_bus_out <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_load) begin
        if (w_has_win) begin
          r_state   <= FULL;
          r_bus_out <= w_data;
          r_grant   <= w_win;
          if (!force_en) begin
            r_ptr <= w_ptr_next;
          end
        end else begin
          r_state <= EMPTY;
          r_grant <= '0;
        end
      end
      if (clr_err) begin
        r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus_out   = r_bus_out;
  assign bus_valid = (r_state == FULL);
  assign grant     = r_grant;
  assign err_cnt   = r_err_cnt;

endmodule
